// File: rtl/muldiv_unit_pkg.sv
// Shared common types: machine word, ALU function codes and multiply/divide operation codes.
package muldiv_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DW    = 2 * XLEN;
    localparam int unsigned CNT_W = 5;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alufunc_t;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    // Absolute value of x when it is to be read as a signed number.
    function automatic word_t magnitude(input word_t x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? word_t'(-x) : x;
    endfunction

    // Two's-complement negation under control of neg.
    function automatic word_t negate_if(input word_t x, input logic neg);
        return neg ? word_t'(-x) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative radix-2 restoring divider on operand magnitudes.
// First cycle with go high loads the magnitudes; the next 32 cycles each retire one quotient bit.
module div_core
    import muldiv_unit_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  flush,
    input  logic  go,
    input  logic  is_signed,
    input  word_t dividend,
    input  word_t divisor,
    output logic  last_c,
    output word_t quotient,
    output word_t remainder
);

    logic             primed;
    logic [CNT_W-1:0] count;
    word_t            rem;
    word_t            quo;
    word_t            dvsr;
    logic [XLEN:0]    shifted;
    logic             fits;
    word_t            step_rem;
    word_t            step_quo;

    // One restoring step: shift the next dividend bit in and subtract the divisor if it fits.
    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        fits     = (shifted >= {1'b0, dvsr});
        step_rem = fits ? word_t'(shifted[XLEN-1:0] - dvsr) : shifted[XLEN-1:0];
        step_quo = {quo[XLEN-2:0], fits};
    end

    assign last_c    = go && primed && (count == CNT_W'(XLEN - 1));
    assign quotient  = quo;
    assign remainder = rem;

    // Partial remainder, quotient shift register and iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            primed <= 1'b0;
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
        end else if (flush) begin
            primed <= 1'b0;
            count  <= '0;
        end else if (go) begin
            if (!primed) begin
                rem    <= '0;
                quo    <= magnitude(dividend, is_signed);
                dvsr   <= magnitude(divisor, is_signed);
                count  <= '0;
                primed <= 1'b1;
            end else begin
                rem   <= step_rem;
                quo   <= step_quo;
                count <= count + CNT_W'(1);
                if (last_c) begin
                    primed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: single-stage registered multiply, iterative divide, shared result fix-up.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    start,
    input  mdu_op_t op,
    input  word_t   a,
    input  word_t   b,
    input  logic    flush,
    output logic    busy,
    output logic    done,
    output word_t   hi,
    output word_t   lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          accept;
    mdu_op_t       op_q;
    word_t         a_q;
    word_t         b_q;
    logic [DW-1:0] prod_q;
    logic [DW-1:0] prod_c;
    logic [DW-1:0] ext_a;
    logic [DW-1:0] ext_b;
    logic          mul_signed;
    logic          div_signed;
    logic          is_div;
    logic          div_last_c;
    word_t         div_quo;
    word_t         div_rem;
    word_t         fix_hi;
    word_t         fix_lo;

    assign busy       = (state != S_IDLE);
    assign accept     = (state == S_IDLE) && start && !flush;
    assign mul_signed = (op_q == MDU_MULT);
    assign div_signed = (op_q == MDU_DIV);
    assign is_div     = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere and outranks start.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = ((op == MDU_DIV) || (op == MDU_DIVU)) ? S_DIV : S_MUL;
                end
            end
            S_MUL:   state_next = S_FIX;
            S_DIV:   if (div_last_c) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // Operand capture on the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= MDU_MULT;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    // 64-bit product; sign-extending to full width makes the low 64 bits correct for both signednesses.
    always_comb begin
        ext_a  = {{XLEN{mul_signed & a_q[XLEN-1]}}, a_q};
        ext_b  = {{XLEN{mul_signed & b_q[XLEN-1]}}, b_q};
        prod_c = ext_a * ext_b;
    end

    // Single registered multiply stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
        end else if (state == S_MUL) begin
            prod_q <= prod_c;
        end
    end

    div_core u_div_core (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .go        (state == S_DIV),
        .is_signed (div_signed),
        .dividend  (a_q),
        .divisor   (b_q),
        .last_c    (div_last_c),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Result selection and signed-divide fix-up; divide by zero yields all-ones quotient and the dividend.
    always_comb begin
        fix_hi = prod_q[DW-1:XLEN];
        fix_lo = prod_q[XLEN-1:0];
        if (is_div) begin
            if (b_q == '0) begin
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_lo = negate_if(div_quo, div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]));
                fix_hi = negate_if(div_rem, div_signed && a_q[XLEN-1]);
            end
        end
    end

    // Result registers and one-cycle done pulse, suppressed by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            done <= (state == S_FIX) && !flush;
            if ((state == S_FIX) && !flush) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic    clk;
    logic    reset;
    logic    start;
    logic    flush;
    logic    busy;
    logic    done;
    mdu_op_t op;
    word_t   a;
    word_t   b;
    word_t   hi;
    word_t   lo;

    int n_cmp;
    int n_bad;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, then wait (bounded) for done and check latency and result.
    task automatic run_op(input string tag, input mdu_op_t o, input word_t x, input word_t y,
                          input int lat, input word_t eh, input word_t el);
        int cyc;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " done low"}, 64'(done), 64'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < lat + 8) begin
            step();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        int cyc;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = MDU_MULT;
        a     = '0;
        b     = '0;

        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        step();
        reset = 1'b0;
        step();
        check("idle busy", 64'(busy), 64'd0);

        run_op("mult neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", MDU_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
        run_op("divu by0", MDU_DIVU, 32'd5, 32'd0, 34, 32'd5, 32'hFFFF_FFFF);
        run_op("div by0 neg", MDU_DIV, 32'hFFFF_FFF0, 32'd0, 34, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000);
        run_op("div mixed", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD);

        // Flush on the tenth DIV cycle.
        step();
        op    = MDU_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        check("flush busy before", 64'(busy), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        seen = 0;
        repeat (40) begin
            step();
            if (done === 1'b1) seen++;
        end
        check("flush no done", 64'(seen), 64'd0);
        check("flush hi kept", 64'(hi), 64'd1);
        check("flush lo kept", 64'(lo), 64'hFFFF_FFFD);

        // Start while busy is ignored.
        op    = MDU_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        repeat (5) begin
            step();
            cyc++;
        end
        op    = MDU_MULT;
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        step();
        cyc++;
        start = 1'b0;
        a     = '0;
        b     = '0;
        while (done !== 1'b1 && cyc < 50) begin
            step();
            cyc++;
        end
        check("ignored start latency", 64'(cyc), 64'd34);
        check("ignored start hi", 64'(hi), 64'd2);
        check("ignored start lo", 64'(lo), 64'd14);
        step();
        check("ignored start not queued", 64'(busy), 64'd0);
        check("done one cycle", 64'(done), 64'd0);

        // Start and flush together in IDLE.
        op    = MDU_MULT;
        a     = 32'd3;
        b     = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        check("start+flush busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (5) begin
            step();
            if (done === 1'b1) seen++;
        end
        check("start+flush no done", 64'(seen), 64'd0);
        check("start+flush hi", 64'(hi), 64'd2);

        // Asynchronous reset between edges in the middle of a divide.
        op    = MDU_DIV;
        a     = 32'hFFFF_FFF9;
        b     = 32'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        #2;
        reset = 1'b1;
        #1;
        check("async busy", 64'(busy), 64'd0);
        check("async done", 64'(done), 64'd0);
        check("async hi", 64'(hi), 64'd0);
        check("async lo", 64'(lo), 64'd0);
        #3;
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            step();
            if (done === 1'b1) seen++;
        end
        check("post reset no done", 64'(seen), 64'd0);
        check("post reset idle", 64'(busy), 64'd0);
        run_op("post reset multu", MDU_MULTU, 32'd6, 32'd7, 2, 32'd0, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request to begin an operation this cycle.
REQ-004 SHALL have port op  input  mdu_op_t  operation select: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU.
REQ-005 SHALL have port a  input  word_t (32)  operand rs; dividend for divide.
REQ-006 SHALL have port b  input  word_t (32)  operand rt; divisor for divide.
REQ-007 SHALL have port flush  input  1  abort the in-flight operation (pipeline exception or redirect).
REQ-008 SHALL have port busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse; hi and lo valid and newly updated.
REQ-010 SHALL have port hi  output  word_t (32)  product[63:32] or remainder.
REQ-011 SHALL have port lo  output  word_t (32)  product[31:0] or quotient.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-013 SHALL accept start only in IDLE, latching op, a and b on that edge.
REQ-014 SHALL ignore start while busy; no queuing, no effect on the running operation.
REQ-015 SHALL assert busy combinationally from state != IDLE; busy is low in the cycle done is high.
REQ-016 SHALL transition IDLE->MUL on accepted MULT/MULTU and IDLE->DIV on accepted DIV/DIVU.
REQ-017 SHALL compute a 64-bit product, signed for MULT and unsigned for MULTU; done high exactly 2 cycles after the start cycle (MUL->FIX->IDLE).
REQ-018 SHALL divide by radix-2 restoring division on operand magnitudes: 32 iteration cycles in DIV, counted 0..31 by a 5-bit counter, then FIX.
REQ-019 SHALL raise done exactly 34 cycles after the start cycle for DIV/DIVU.
REQ-020 SHALL apply signed-divide sign rules in FIX: quotient negated when a[31]^b[31]; remainder takes the sign of a.
REQ-021 SHALL return lo=32'hFFFF_FFFF, hi=a for b==0 (DIV and DIVU), at normal divide latency, with no exception.
REQ-022 SHALL return lo=32'h8000_0000, hi=0 for DIV 32'h8000_0000 / 32'hFFFF_FFFF, with no overflow flag.
REQ-023 SHALL register hi and lo in FIX and hold them until the next FIX; done is registered and high for exactly one cycle.
REQ-024 SHALL return to IDLE on the edge where flush is high, from any state, with no done and hi/lo unchanged.
REQ-025 SHALL give flush priority over start in the same cycle: the operation is not accepted.
REQ-026 SHALL accept a new start in the cycle done is high, since state is IDLE then.

Reset
REQ-027 SHALL on reset force state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, regardless of clk.
REQ-028 SHALL discard any in-flight operation when reset is asserted mid-operation; first done after release requires a fresh start.

Structure
REQ-029 SHALL define mdu_op_t (2-bit enum) in the shared common package alongside alufunc_t; word_t is taken from there.
REQ-030 SHALL place the iterative divider datapath (partial remainder, quotient shift register, counter) in sub-module div_core; the multiply and FSM stay in muldiv_unit.
REQ-031 SHALL contain no latches; the multiply uses a single registered stage.

Verification
REQ-032 SHALL cover MULT a=32'hFFFF_FFFE (-2), b=3 -> done at start+2, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
REQ-033 SHALL cover MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-034 SHALL cover DIV a=-7 (32'hFFFF_FFF9), b=2 -> done at start+34, lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-035 SHALL cover DIVU a=5, b=0 -> lo=32'hFFFF_FFFF, hi=5; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-036 SHALL cover flush at DIV cycle 10 -> busy low next cycle, no done, hi/lo keep prior values; start during busy -> ignored, original result delivered.
REQ-037 SHALL cover async reset asserted mid-DIV between edges -> busy, done, hi, lo all 0 immediately; start+flush together in IDLE -> no operation.
